string_hw_csr: RTL and testbench

Avalon-MM slave front end that lets the NIOS2 drive the string accelerator (`String_HW`) through memory-mapped registers. It latches operands and opcode from CPU writes and runs the accelerator's go/done handshake as the initiator: it raises go, waits for done, captures the result and drops go. It sits between the Avalon interconnect and one `String_HW` instance and replaces the bench-driven go/done sequencing with a CPU-visible register block.

---
 rtl/string_hw_pkg.sv | 27 ++
 rtl/string_hw_csr_fsm.sv | 75 +++++++
 rtl/string_hw_csr.sv | 160 ++++++++++++++++
 tb/tb_string_hw_csr.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/string_hw_pkg.sv
// rtl/string_hw_pkg.sv - shared types and constants for the String_HW CSR block
// Purpose: opcode enum, register word addresses, character width, FSM states.
// Ports: none (package).
package string_hw_pkg;

  localparam int CHAR_W = 8;

  typedef enum logic [2:0] {
    OP_CMP   = 3'd0,
    OP_UPPER = 3'd1,
    OP_LOWER = 3'd2
  } op_e;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_A      = 3'd1;
  localparam logic [2:0] ADDR_B      = 3'd2;
  localparam logic [2:0] ADDR_LEN    = 3'd3;
  localparam logic [2:0] ADDR_RESULT = 3'd4;
  localparam logic [2:0] ADDR_IRQ    = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GO      = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/string_hw_csr_fsm.sv
// rtl/string_hw_csr_fsm.sv - go/done initiator FSM with timeout counter
// Purpose: runs IDLE -> GO -> RELEASE around one accelerator operation.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          valid start request (only honoured in IDLE)
//   acc_done       done from the accelerator
//   limit          last GO count value before timing out (TIMEOUT-1)
//   acc_go         go to the accelerator
//   busy           state != IDLE
//   capture        one-cycle strobe: latch the result now
//   timeout        one-cycle strobe: operation aborted
module string_hw_csr_fsm
  import string_hw_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             acc_done,
  input  logic [CNT_W-1:0] limit,
  output logic             acc_go,
  output logic             busy,
  output logic             capture,
  output logic             timeout
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_go  = 1'b0;
    capture = 1'b0;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_GO;
          cnt_d   = '0;
        end
      end
      ST_GO: begin
        acc_go = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        // done takes priority over a simultaneous timeout
        if (acc_done) begin
          capture = 1'b1;
          state_d = ST_RELEASE;
        end else if (cnt_q == limit) begin
          timeout = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!acc_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: rtl/string_hw_csr.sv
// rtl/string_hw_csr.sv - Avalon-MM register front end driving one String_HW
// Purpose: latches operands/opcode from CPU writes, runs go/done, captures result.
// Optional feature macro: STRING_HW_CSR_IRQ_EN (IRQ register at address 5, irq port).
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   address, chipselect, write,
//   writedata, read, readdata           Avalon-MM slave, read latency 1
//   acc_go, acc_index, acc_A, acc_B,
//   acc_lengthA, acc_lengthB            command/operands to the accelerator
//   acc_done, acc_result                response from the accelerator
//   irq                                 interrupt (macro build only)
module string_hw_csr
  import string_hw_pkg::*;
#(
  parameter int MAX_LEN = 2,
  parameter int CHAR_W  = string_hw_pkg::CHAR_W,
  parameter int TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2:0]                   address,
  input  logic                         chipselect,
  input  logic                         write,
  input  logic [31:0]                  writedata,
  input  logic                         read,
  output logic [31:0]                  readdata,
  output logic                         acc_go,
  output logic [2:0]                   acc_index,
  output logic [MAX_LEN*CHAR_W-1:0]    acc_A,
  output logic [MAX_LEN*CHAR_W-1:0]    acc_B,
  output logic [$clog2(MAX_LEN+1)-1:0] acc_lengthA,
  output logic [$clog2(MAX_LEN+1)-1:0] acc_lengthB,
  input  logic                         acc_done,
  input  logic [MAX_LEN*CHAR_W-1:0]    acc_result
`ifdef STRING_HW_CSR_IRQ_EN
  ,
  output logic                         irq
`endif
);

  localparam int W     = MAX_LEN * CHAR_W;
  localparam int LW    = $clog2(MAX_LEN + 1);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0]  a_q, b_q, result_q;
  logic [LW-1:0] lena_q, lenb_q;
  logic [2:0]    index_q;
  logic          done_q, timeout_q, bad_op_q;
  logic [31:0]   readdata_q, rdata;

  logic busy, capture, to_strobe;
  logic wr_en, rd_en, idle_wr, ctrl_wr, start_req, start_ok;

  assign wr_en     = chipselect & write;
  assign rd_en     = chipselect & read;
  // operand, LEN and CTRL writes are dropped while an operation is running
  assign idle_wr   = wr_en & ~busy;
  assign ctrl_wr   = idle_wr && (address == ADDR_CTRL);
  assign start_req = ctrl_wr & writedata[0];
  assign start_ok  = start_req && (writedata[3:1] <= 3'(OP_LOWER));

  function automatic logic [LW-1:0] clamp_len(input logic [7:0] v);
    return (v > 8'(MAX_LEN)) ? LW'(MAX_LEN) : v[LW-1:0];
  endfunction

  string_hw_csr_fsm #(.CNT_W(CNT_W)) u_fsm (
    .clk      (clk),
    .reset    (reset),
    .start    (start_ok),
    .acc_done (acc_done),
    .limit    (CNT_W'(TIMEOUT - 1)),
    .acc_go   (acc_go),
    .busy     (busy),
    .capture  (capture),
    .timeout  (to_strobe)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      lena_q     <= '0;
      lenb_q     <= '0;
      index_q    <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      bad_op_q   <= 1'b0;
      readdata_q <= '0;
    end else begin
      if (idle_wr && address == ADDR_A) a_q <= writedata[W-1:0];
      if (idle_wr && address == ADDR_B) b_q <= writedata[W-1:0];
      if (idle_wr && address == ADDR_LEN) begin
        lena_q <= clamp_len(writedata[7:0]);
        lenb_q <= clamp_len(writedata[15:8]);
      end
      if (ctrl_wr) index_q <= writedata[3:1];
      if (start_req) begin
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
        bad_op_q  <= ~start_ok;
      end
      // capture/timeout only occur while busy, so they never collide with start_req
      if (capture) begin
        result_q <= acc_result;
        done_q   <= 1'b1;
      end
      if (to_strobe) timeout_q <= 1'b1;
      readdata_q <= rd_en ? rdata : '0;
    end
  end

`ifdef STRING_HW_CSR_IRQ_EN
  logic irq_en_q, irq_q;
  logic irq_wr;

  assign irq_wr = wr_en && (address == ADDR_IRQ);

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (irq_wr) irq_en_q <= writedata[0];
      // set wins over a same-cycle clear
      if ((capture | to_strobe) && irq_en_q) irq_q <= 1'b1;
      else if ((irq_wr && writedata[1]) || start_req) irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    rdata = '0;
    case (address)
      ADDR_CTRL:   rdata = {25'b0, index_q, bad_op_q, timeout_q, done_q, busy};
      ADDR_A:      rdata = 32'(a_q);
      ADDR_B:      rdata = 32'(b_q);
      ADDR_LEN:    rdata = {16'b0, 8'(lenb_q), 8'(lena_q)};
      ADDR_RESULT: rdata = 32'(result_q);
`ifdef STRING_HW_CSR_IRQ_EN
      ADDR_IRQ:    rdata = {30'b0, irq_q, irq_en_q};
`endif
      default:     rdata = '0;
    endcase
  end

  // upper writedata bits are only meaningful for some registers
  logic unused_wd;
  assign unused_wd = ^writedata;

  assign readdata    = readdata_q;
  assign acc_index   = index_q;
  assign acc_A       = a_q;
  assign acc_B       = b_q;
  assign acc_lengthA = lena_q;
  assign acc_lengthB = lenb_q;

endmodule

// File: tb/tb_string_hw_csr.sv
// tb/tb_string_hw_csr.sv - self-checking bench for string_hw_csr
module tb_string_hw_csr;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic        acc_go;
  logic [2:0]  acc_index;
  logic [15:0] acc_A, acc_B;
  logic [1:0]  acc_lengthA, acc_lengthB;
  logic        acc_done;
  logic [15:0] acc_result;
`ifdef STRING_HW_CSR_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad = 0;
  logic stall = 1'b0;
  int lat_cnt;
  int go_cycles = 0;

  always #5 clk = ~clk;

  string_hw_csr #(.MAX_LEN(2), .CHAR_W(8), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .chipselect  (chipselect),
    .write       (write),
    .writedata   (writedata),
    .read        (read),
    .readdata    (readdata),
    .acc_go      (acc_go),
    .acc_index   (acc_index),
    .acc_A       (acc_A),
    .acc_B       (acc_B),
    .acc_lengthA (acc_lengthA),
    .acc_lengthB (acc_lengthB),
    .acc_done    (acc_done),
    .acc_result  (acc_result)
`ifdef STRING_HW_CSR_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  // Behavioural accelerator: answers two cycles after go, holds done until go drops.
  function automatic logic [15:0] acc_model(input logic [2:0] idx, input logic [15:0] a,
                                            input logic [15:0] b, input logic [1:0] la,
                                            input logic [1:0] lb);
    logic [15:0] r;
    logic [7:0]  c;
    logic        eq;
    r  = '0;
    eq = (la == lb);
    for (int i = 0; i < 2; i++) begin
      if (i < int'(la)) begin
        c = a[15-8*i -: 8];
        if (a[15-8*i -: 8] != b[15-8*i -: 8]) eq = 1'b0;
        if (idx == 3'd1 && c >= 8'h61 && c <= 8'h7a) c = c - 8'h20;
        if (idx == 3'd2 && c >= 8'h41 && c <= 8'h5a) c = c + 8'h20;
        r[15-8*i -: 8] = c;
      end
    end
    if (idx == 3'd0) r = {15'b0, eq};
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      acc_done   <= 1'b0;
      acc_result <= '0;
      lat_cnt    <= 0;
    end else if (acc_go && !acc_done && !stall) begin
      if (lat_cnt == 1) begin
        acc_done   <= 1'b1;
        acc_result <= acc_model(acc_index, acc_A, acc_B, acc_lengthA, acc_lengthB);
        lat_cnt    <= 0;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else if (!acc_go) begin
      acc_done <= 1'b0;
      lat_cnt  <= 0;
    end
  end

  always @(negedge clk) if (acc_go) go_cycles <= go_cycles + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] d;
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      bus_read(3'd0, d);
      if (!d[0]) begin ok = 1'b1; break; end
    end
    if (!ok) check({name, " idle-timeout"}, 32'd1, 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] a, b, len, ctrl;
    logic [31:0] exp_res, exp_ctrl;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] d;
    int g0;

    vecs[0] = '{"cmp_eq",   32'h6162, 32'h6162, 32'h0202, 32'h1, 32'h0001, 32'h02};
    vecs[1] = '{"cmp_ne",   32'h6162, 32'h6163, 32'h0202, 32'h1, 32'h0000, 32'h02};
    vecs[2] = '{"upper",    32'h6142, 32'h0000, 32'h0002, 32'h3, 32'h4142, 32'h12};
    vecs[3] = '{"lower",    32'h6142, 32'h0000, 32'h0202, 32'h5, 32'h6162, 32'h22};
    vecs[4] = '{"cmp_len",  32'h6162, 32'h6162, 32'h0201, 32'h1, 32'h0000, 32'h02};
    vecs[5] = '{"upper_l1", 32'h6162, 32'h0000, 32'h0001, 32'h3, 32'h4100, 32'h12};

    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset acc_go", 32'(acc_go), 32'd0);
    check("reset acc_A", 32'(acc_A), 32'd0);
    for (int r = 0; r < 6; r++) begin
      bus_read(3'(r), d);
      check($sformatf("reset reg%0d", r), d, 32'd0);
    end

    for (int v = 0; v < 6; v++) begin
      bus_write(3'd1, vecs[v].a);
      bus_write(3'd2, vecs[v].b);
      bus_write(3'd3, vecs[v].len);
      g0 = go_cycles;
      bus_write(3'd0, vecs[v].ctrl);
      wait_idle(vecs[v].name);
      check({vecs[v].name, " go_seen"}, 32'(go_cycles > g0), 32'd1);
      bus_read(3'd4, d);
      check({vecs[v].name, " result"}, d, vecs[v].exp_res);
      bus_read(3'd0, d);
      check({vecs[v].name, " ctrl"}, d, vecs[v].exp_ctrl);
    end

    // busy protection + timeout with a silent accelerator
`ifdef STRING_HW_CSR_IRQ_EN
    bus_write(3'd5, 32'h1);
`endif
    stall = 1'b1;
    bus_write(3'd1, 32'h1111);
    bus_write(3'd3, 32'h0202);
    g0 = go_cycles;
    bus_write(3'd0, 32'h1);
    bus_write(3'd1, 32'h2222);
    check("busy acc_A", 32'(acc_A), 32'h1111);
    bus_read(3'd0, d);
    check("busy ctrl", d, 32'h01);
    bus_read(3'd1, d);
    check("busy A readback", d, 32'h1111);
    wait_idle("timeout");
    check("timeout go cycles", 32'(go_cycles - g0), 32'd16);
    bus_read(3'd0, d);
    check("timeout ctrl", d, 32'h04);
    bus_read(3'd4, d);
    check("timeout result kept", d, 32'h4100);
`ifdef STRING_HW_CSR_IRQ_EN
    check("irq set", 32'(irq), 32'd1);
    bus_write(3'd5, 32'h3);
    check("irq cleared", 32'(irq), 32'd0);
`endif
    stall = 1'b0;

    // bad opcode
    g0 = go_cycles;
    bus_write(3'd0, 32'hF);
    repeat (5) @(negedge clk);
    check("bad_op no go", 32'(go_cycles - g0), 32'd0);
    bus_read(3'd0, d);
    check("bad_op ctrl", d, 32'h78);

    // LEN clamp, RESULT read-only, unmapped address
    bus_write(3'd3, 32'h0909);
    bus_read(3'd3, d);
    check("len clamp", d, 32'h0202);
    bus_write(3'd4, 32'hBEEF);
    bus_read(3'd4, d);
    check("result ro", d, 32'h4100);
    bus_read(3'd6, d);
    check("addr6 zero", d, 32'd0);

    // reset while in GO
    stall = 1'b1;
    bus_write(3'd0, 32'h1);
    for (int i = 0; i < 10 && !acc_go; i++) @(negedge clk);
    check("go before reset", 32'(acc_go), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset go low", 32'(acc_go), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    check("reset2 acc_A", 32'(acc_A), 32'd0);
    for (int r = 0; r < 6; r++) begin
      bus_read(3'(r), d);
      check($sformatf("reset2 reg%0d", r), d, 32'd0);
    end
`ifdef STRING_HW_CSR_IRQ_EN
    check("reset2 irq", 32'(irq), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
